// File: rtl/gru_candidate_gate_element.sv
// One element of the GRU candidate state: sequential MAC over the input row and
// the hidden row, reset-gate scaling, saturation and a piecewise-linear tanh.
module gru_candidate_gate_element #(
    parameter int D          = 128,
    parameter int H          = 256,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid_in,
    input  logic [DATA_WIDTH-1:0]            r_t_n,
    input  logic [D-1:0][DATA_WIDTH-1:0]     x_t,
    input  logic [H-1:0][DATA_WIDTH-1:0]     h_t_prev,
    input  logic [D-1:0][DATA_WIDTH-1:0]     W_in_row,
    input  logic [H-1:0][DATA_WIDTH-1:0]     W_hn_row,
    input  logic [DATA_WIDTH-1:0]            b_in_n,
    input  logic [DATA_WIDTH-1:0]            b_hn_n,
    output logic [DATA_WIDTH-1:0]            n_t_n,
    output logic                             valid_out,
    output logic                             busy
);

    localparam int MAX_DH = (D > H) ? D : H;
    localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(MAX_DH);
    localparam int CNT_W  = ($clog2(MAX_DH) > 0) ? $clog2(MAX_DH) : 1;
    localparam int IW     = (D > 1) ? $clog2(D) : 1;
    localparam int HW     = (H > 1) ? $clog2(H) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int SC_W   = ACC_W + DATA_WIDTH;
    localparam int PRE_W  = SC_W + 2;
    localparam int TW     = DATA_WIDTH + 1;

    localparam logic signed [PRE_W-1:0] SAT_MAX =
        {{(PRE_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PRE_W-1:0] SAT_MIN =
        {{(PRE_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // tanh breakpoints: 0.5, 2.5, offset 0.375 and 1.0 in the output format
    localparam logic signed [TW-1:0]         T_HALF     = TW'(1 << (FRAC_BITS - 1));
    localparam logic signed [TW-1:0]         T_TWO_HALF = TW'(5 << (FRAC_BITS - 1));
    localparam logic signed [TW-1:0]         T_OFFSET   = TW'(3 << (FRAC_BITS - 3));
    localparam logic signed [DATA_WIDTH-1:0] T_ONE      = DATA_WIDTH'(1 << FRAC_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC_INPUT,
        S_MAC_HIDDEN,
        S_SCALE,
        S_COMBINE,
        S_TANH,
        S_DONE
    } state_t;

    state_t                         state_reg, state_next;
    logic [CNT_W-1:0]               cnt_reg;
    logic signed [ACC_W-1:0]        sum_i_reg, sum_h_reg;
    logic signed [DATA_WIDTH-1:0]   r_reg;
    logic signed [SC_W-1:0]         scaled_reg;
    logic signed [DATA_WIDTH-1:0]   pre_reg;
    logic [DATA_WIDTH-1:0]          n_t_n_reg;
    logic                           valid_out_reg;

    // Signed element views of the packed vector ports
    logic signed [DATA_WIDTH-1:0]   x_s      [D];
    logic signed [DATA_WIDTH-1:0]   w_in_s   [D];
    logic signed [DATA_WIDTH-1:0]   h_s      [H];
    logic signed [DATA_WIDTH-1:0]   w_hn_s   [H];

    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_in_view
            assign x_s[gi]    = x_t[gi];
            assign w_in_s[gi] = W_in_row[gi];
        end
        for (gi = 0; gi < H; gi++) begin : g_hid_view
            assign h_s[gi]    = h_t_prev[gi];
            assign w_hn_s[gi] = W_hn_row[gi];
        end
    endgenerate

    logic [IW-1:0]                  idx_i;
    logic [HW-1:0]                  idx_h;
    logic                           last_i, last_h;
    logic signed [PROD_W-1:0]       prod_i, prod_h;
    logic signed [DATA_WIDTH-1:0]   b_in_s, b_hn_s;

    assign idx_i  = cnt_reg[IW-1:0];
    assign idx_h  = cnt_reg[HW-1:0];
    assign last_i = (cnt_reg == CNT_W'(D - 1));
    assign last_h = (cnt_reg == CNT_W'(H - 1));
    assign prod_i = x_s[idx_i] * w_in_s[idx_i];
    assign prod_h = h_s[idx_h] * w_hn_s[idx_h];
    assign b_in_s = b_in_n;
    assign b_hn_s = b_hn_n;

    // Reset-gate product: r * ((sum_h >>> F) + b_hn), rescaled back to Q.F
    logic signed [ACC_W-1:0]        sum_h_sh, hterm;
    logic signed [SC_W-1:0]         r_prod, scaled_next;

    assign sum_h_sh    = sum_h_reg >>> FRAC_BITS;
    assign hterm       = sum_h_sh + ACC_W'(b_hn_s);
    assign r_prod      = r_reg * hterm;
    assign scaled_next = r_prod >>> FRAC_BITS;

    // Pre-activation in full width, then clamp to the data range
    logic signed [ACC_W-1:0]        sum_i_sh;
    logic signed [PRE_W-1:0]        pre_full;
    logic signed [DATA_WIDTH-1:0]   pre_sat;

    assign sum_i_sh = sum_i_reg >>> FRAC_BITS;
    assign pre_full = PRE_W'(sum_i_sh) + PRE_W'(b_in_s) + PRE_W'(scaled_reg);

    always_comb begin
        pre_sat = pre_full[DATA_WIDTH-1:0];
        if (pre_full > SAT_MAX) begin
            pre_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (pre_full < SAT_MIN) begin
            pre_sat = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // Piecewise-linear tanh; one extra bit so |-2^(DW-1)| is representable
    logic signed [TW-1:0]           pre_ext, mag, lin;
    logic                           pre_neg;
    logic signed [DATA_WIDTH-1:0]   tanh_val;

    assign pre_ext = TW'(pre_reg);
    assign pre_neg = pre_ext[TW-1];
    assign mag     = pre_neg ? -pre_ext : pre_ext;
    assign lin     = (mag >>> 2) + T_OFFSET;

    always_comb begin
        tanh_val = pre_reg;
        if (mag >= T_TWO_HALF) begin
            tanh_val = pre_neg ? -T_ONE : T_ONE;
        end else if (mag >= T_HALF) begin
            tanh_val = pre_neg ? DATA_WIDTH'(-lin) : DATA_WIDTH'(lin);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:       if (valid_in) state_next = S_MAC_INPUT;
            S_MAC_INPUT:  if (last_i)   state_next = S_MAC_HIDDEN;
            S_MAC_HIDDEN: if (last_h)   state_next = S_SCALE;
            S_SCALE:      state_next = S_COMBINE;
            S_COMBINE:    state_next = S_TANH;
            S_TANH:       state_next = S_DONE;
            S_DONE:       state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            sum_i_reg     <= '0;
            sum_h_reg     <= '0;
            r_reg         <= '0;
            scaled_reg    <= '0;
            pre_reg       <= '0;
            n_t_n_reg     <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (valid_in) begin
                        r_reg     <= r_t_n;
                        sum_i_reg <= '0;
                        sum_h_reg <= '0;
                        cnt_reg   <= '0;
                    end
                end
                S_MAC_INPUT: begin
                    sum_i_reg <= sum_i_reg + ACC_W'(prod_i);
                    cnt_reg   <= last_i ? '0 : cnt_reg + CNT_W'(1);
                end
                S_MAC_HIDDEN: begin
                    sum_h_reg <= sum_h_reg + ACC_W'(prod_h);
                    cnt_reg   <= last_h ? '0 : cnt_reg + CNT_W'(1);
                end
                S_SCALE: begin
                    scaled_reg <= scaled_next;
                end
                S_COMBINE: begin
                    pre_reg <= pre_sat;
                end
                S_TANH: begin
                    n_t_n_reg     <= tanh_val;
                    valid_out_reg <= 1'b1;
                end
                S_DONE: begin
                    valid_out_reg <= 1'b0;
                end
                default: begin
                    valid_out_reg <= 1'b0;
                end
            endcase
        end
    end

    assign n_t_n     = n_t_n_reg;
    assign valid_out = valid_out_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_gru_candidate_gate_element.sv
// Scenario bench for gru_candidate_gate_element (D=4, H=4, F=8): expected results
// are queued at accept and compared when valid_out pulses.
module tb_gru_candidate_gate_element;

    localparam int D  = 4;
    localparam int H  = 4;
    localparam int DW = 16;
    localparam int LAT = 11;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   valid_in;
    logic [DW-1:0]          r_t_n, b_in_n, b_hn_n;
    logic [D-1:0][DW-1:0]   x_t, W_in_row;
    logic [H-1:0][DW-1:0]   h_t_prev, W_hn_row;
    logic [DW-1:0]          n_t_n;
    logic                   valid_out, busy;

    int checks = 0;
    int errors = 0;
    logic signed [DW-1:0] exp_q[$];

    gru_candidate_gate_element #(
        .D(D), .H(H), .DATA_WIDTH(DW), .FRAC_BITS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .r_t_n(r_t_n),
        .x_t(x_t), .h_t_prev(h_t_prev), .W_in_row(W_in_row), .W_hn_row(W_hn_row),
        .b_in_n(b_in_n), .b_hn_n(b_hn_n), .n_t_n(n_t_n),
        .valid_out(valid_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_vec(input int r, input int xv, input int wi, input int wh,
                           input int hv, input int bi, input int bh);
        r_t_n  = DW'(r);
        b_in_n = DW'(bi);
        b_hn_n = DW'(bh);
        for (int i = 0; i < D; i++) begin
            x_t[i]      = DW'(xv);
            W_in_row[i] = DW'(wi);
        end
        for (int j = 0; j < H; j++) begin
            h_t_prev[j] = DW'(hv);
            W_hn_row[j] = DW'(wh);
        end
    endtask

    // Pulses valid_in for one edge; returns #1 after the accept edge
    task automatic start_txn(input logic signed [DW-1:0] expv);
        @(posedge clk); #1;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        exp_q.push_back(expv);
    endtask

    task automatic wait_valid(output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            seen = valid_out;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0;
        set_vec(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (n_t_n !== '0 || valid_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: n_t_n=%0d valid_out=%b busy=%b, required 0/0/0",
                     $signed(n_t_n), valid_out, busy);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_zero_weights();
        int cyc; bit seen; logic signed [DW-1:0] expv;
        set_vec(0, 0, 0, 0, 0, 0, 0);
        start_txn(16'sd0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL zero_accept: busy=%b, required 1", busy); end
        wait_valid(cyc, seen);
        checks++;
        if (!seen || exp_q.size() == 0) begin
            errors++; exp_q.delete();
            $display("FAIL zero_timeout: no valid_out within %0d cycles", cyc);
        end else begin
            expv = exp_q.pop_front();
            $display("txn zero: n_t_n=%0d latency=%0d", $signed(n_t_n), cyc);
            if (n_t_n !== expv) begin errors++; $display("FAIL zero_value: got %0d, required %0d", $signed(n_t_n), expv); end
            checks++;
            if (cyc !== LAT) begin errors++; $display("FAIL zero_latency: got %0d, required %0d", cyc, LAT); end
        end
        @(posedge clk); #1;
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: valid_out=%b busy=%b, required 0/0", valid_out, busy);
        end
    endtask

    task automatic test_hidden_ignored();
        int cyc; bit seen; logic signed [DW-1:0] expv;
        set_vec(0, 64, 256, 256, 256, 0, 0);
        start_txn(16'sd160);
        wait_valid(cyc, seen);
        checks++;
        if (!seen || exp_q.size() == 0) begin
            errors++; exp_q.delete();
            $display("FAIL r0_timeout: no valid_out within %0d cycles", cyc);
        end else begin
            expv = exp_q.pop_front();
            $display("txn r0: n_t_n=%0d latency=%0d", $signed(n_t_n), cyc);
            if (n_t_n !== expv) begin errors++; $display("FAIL r0_value: got %0d, required %0d", $signed(n_t_n), expv); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_linear_region();
        int cyc; bit seen; logic signed [DW-1:0] expv;
        set_vec(256, 0, 0, 256, 16, 0, 0);
        start_txn(16'sd64);
        wait_valid(cyc, seen);
        checks++;
        if (!seen || exp_q.size() == 0) begin
            errors++; exp_q.delete();
            $display("FAIL linear_timeout: no valid_out within %0d cycles", cyc);
        end else begin
            expv = exp_q.pop_front();
            $display("txn linear: n_t_n=%0d latency=%0d", $signed(n_t_n), cyc);
            if (n_t_n !== expv) begin errors++; $display("FAIL linear_value: got %0d, required %0d", $signed(n_t_n), expv); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        int cyc; bit seen; logic signed [DW-1:0] expv;
        int xs[3]                   = '{32767, -32767, 0};
        int bs[3]                   = '{0, 0, -100};
        logic signed [DW-1:0] es[3] = '{16'sd256, -16'sd256, -16'sd100};
        for (int k = 0; k < 3; k++) begin
            set_vec(0, xs[k], (k == 2) ? 0 : 32767, 0, 0, bs[k], 0);
            start_txn(es[k]);
            wait_valid(cyc, seen);
            checks++;
            if (!seen || exp_q.size() == 0) begin
                errors++; exp_q.delete();
                $display("FAIL sat%0d_timeout: no valid_out within %0d cycles", k, cyc);
            end else begin
                expv = exp_q.pop_front();
                $display("txn sat%0d: n_t_n=%0d latency=%0d", k, $signed(n_t_n), cyc);
                if (n_t_n !== expv) begin errors++; $display("FAIL sat%0d_value: got %0d, required %0d", k, $signed(n_t_n), expv); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic exp_busy, exp_v;
        logic signed [DW-1:0] expv;
        set_vec(0, 64, 256, 256, 256, 0, 0);
        @(posedge clk); #1;
        valid_in = 1'b1;
        exp_q.push_back(16'sd160);
        for (int c = 0; c <= 30; c++) begin
            @(posedge clk); #1;
            exp_busy = !(c == 12 || c >= 25);
            exp_v    = (c == 11 || c == 24);
            checks++;
            if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy c=%0d: got %b, required %b", c, busy, exp_busy); end
            checks++;
            if (valid_out !== exp_v) begin errors++; $display("FAIL b2b_valid c=%0d: got %b, required %b", c, valid_out, exp_v); end
            if (valid_out === 1'b1) begin
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra c=%0d: unexpected result %0d", c, $signed(n_t_n));
                end else begin
                    expv = exp_q.pop_front();
                    $display("txn b2b%0d: n_t_n=%0d cycle=%0d", pulses, $signed(n_t_n), c);
                    if (n_t_n !== expv) begin errors++; $display("FAIL b2b_value c=%0d: got %0d, required %0d", c, $signed(n_t_n), expv); end
                end
            end
            if (c == 11) begin
                set_vec(256, 0, 0, 256, 16, 0, 0);
                exp_q.push_back(16'sd64);
            end
            if (c == 13) valid_in = 1'b0;
        end
        checks++;
        if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d, required 2", pulses); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_op();
        int cyc; bit seen; logic signed [DW-1:0] expv;
        set_vec(0, 64, 256, 256, 256, 0, 0);
        start_txn(16'sd160);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b, required 1", busy); end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (n_t_n !== '0 || valid_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: n_t_n=%0d valid_out=%b busy=%b, required 0/0/0",
                     $signed(n_t_n), valid_out, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_vec(256, 0, 0, 256, 16, 0, 0);
        start_txn(16'sd64);
        wait_valid(cyc, seen);
        checks++;
        if (!seen || exp_q.size() == 0) begin
            errors++; exp_q.delete();
            $display("FAIL midrst_timeout: no valid_out within %0d cycles", cyc);
        end else begin
            expv = exp_q.pop_front();
            $display("txn after_reset: n_t_n=%0d latency=%0d", $signed(n_t_n), cyc);
            if (n_t_n !== expv) begin errors++; $display("FAIL midrst_value: got %0d, required %0d", $signed(n_t_n), expv); end
            checks++;
            if (cyc !== LAT) begin errors++; $display("FAIL midrst_latency: got %0d, required %0d", cyc, LAT); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_zero_weights();
        test_hidden_ignored();
        test_linear_region();
        test_saturation();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
